// File: rtl/ntt_sched_if.sv
// Control/issue/write-back bundle between the NTT scheduler and its datapath.
// master = scheduler, slave = datapath/host side.
interface ntt_sched_if;
  logic       start;
  logic       inverse;
  logic       busy;
  logic       done;
  logic       bf_valid;
  logic       bf_ready;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [7:0] zeta_addr;
  logic       zeta_neg;
  logic [2:0] stage;
  logic       wb_valid;
  logic [7:0] wb_addr_a;
  logic [7:0] wb_addr_b;

  modport master (
    input  start, inverse, bf_ready,
    output busy, done, bf_valid, rd_addr_a, rd_addr_b, zeta_addr, zeta_neg,
           stage, wb_valid, wb_addr_a, wb_addr_b
  );

  modport slave (
    output start, inverse, bf_ready,
    input  busy, done, bf_valid, rd_addr_a, rd_addr_b, zeta_addr, zeta_neg,
           stage, wb_valid, wb_addr_a, wb_addr_b
  );
endinterface

// File: rtl/ntt_sched_ctrl.sv
// 256-point NTT butterfly scheduler: issues 8 stages x 128 butterflies (CT forward
// or GS inverse) and mirrors each accepted issue to write-back BF_LAT cycles later.
module ntt_sched_ctrl #(
  parameter int BF_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  ntt_sched_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [6:0] b_q, b_d;
  logic       inv_q, inv_d;
  logic       issue, acc, pend;

  logic [BF_LAT:1]       vld_pipe;
  logic [BF_LAT:1][7:0]  a_pipe, b_pipe;

  logic [7:0] bx, grp, lmask, addr_a, addr_b, zeta;

  // Butterfly index -> coefficient pair and twiddle address
  always_comb begin
    bx     = {1'b0, b_q};
    grp    = 8'd0;
    lmask  = 8'd0;
    addr_a = 8'd0;
    addr_b = 8'd0;
    zeta   = 8'd0;
    if (!inv_q) begin
      grp    = bx >> (3'd7 - s_q);
      lmask  = (8'd128 >> s_q) - 8'd1;
      addr_a = (grp << (4'd8 - {1'b0, s_q})) + (bx & lmask);
      addr_b = addr_a + (8'd128 >> s_q);
      zeta   = (8'd1 << s_q) + grp;
    end else begin
      grp    = bx >> s_q;
      lmask  = (8'd1 << s_q) - 8'd1;
      addr_a = (grp << ({1'b0, s_q} + 4'd1)) + (bx & lmask);
      addr_b = addr_a + (8'd1 << s_q);
      // (256>>s)-1 == 255>>s keeps the twiddle math in 8 bits
      zeta   = (8'd255 >> s_q) - grp;
    end
  end

  assign issue = (state_q == ISSUE);
  assign acc   = issue & bus.bf_ready;

  // Only the oldest slot may still be occupied when leaving DRAIN, so the next
  // stage's first read lands the cycle after the final write-back.
  always_comb begin
    pend = 1'b0;
    for (int i = 1; i < BF_LAT; i++) pend = pend | vld_pipe[i];
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ISSUE;
        s_d     = 3'd0;
        b_d     = 7'd0;
        inv_d   = bus.inverse;
      end
      ISSUE: if (acc) begin
        b_d = b_q + 7'd1;
        if (b_q == 7'd127) begin
          state_d = DRAIN;
          b_d     = 7'd0;
        end
      end
      DRAIN: if (!pend) begin
        if (s_q == 3'd7) state_d = FINISH;
        else begin
          state_d = ISSUE;
          s_d     = s_q + 3'd1;
          b_d     = 7'd0;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= 3'd0;
      b_q     <= 7'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      inv_q   <= inv_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[1] <= acc;
      a_pipe[1]   <= acc ? addr_a : 8'd0;
      b_pipe[1]   <= acc ? addr_b : 8'd0;
      for (int i = 2; i <= BF_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        a_pipe[i]   <= a_pipe[i-1];
        b_pipe[i]   <= b_pipe[i-1];
      end
    end
  end

  assign bus.busy      = (state_q == ISSUE) | (state_q == DRAIN);
  assign bus.done      = (state_q == FINISH);
  assign bus.bf_valid  = issue;
  assign bus.rd_addr_a = issue ? addr_a : 8'd0;
  assign bus.rd_addr_b = issue ? addr_b : 8'd0;
  assign bus.zeta_addr = issue ? zeta   : 8'd0;
  assign bus.zeta_neg  = inv_q;
  assign bus.stage     = s_q;
  assign bus.wb_valid  = vld_pipe[BF_LAT];
  assign bus.wb_addr_a = a_pipe[BF_LAT];
  assign bus.wb_addr_b = b_pipe[BF_LAT];

endmodule

// File: tb/tb_ntt_sched_ctrl.sv
// Directed bench for ntt_sched_ctrl: forward/inverse schedules from a reference
// loop nest, stalls, stage boundaries, mid-run reset and ignored start.
module tb_ntt_sched_ctrl;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ntt_sched_if bus();
  ntt_sched_ctrl #(.BF_LAT(L)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] z;
    logic [7:0] a;
    logic [7:0] b;
  } iss_t;

  iss_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {bus.busy, bus.done, bus.bf_valid, bus.wb_valid, bus.zeta_neg, bus.stage,
              bus.rd_addr_a, bus.rd_addr_b, bus.zeta_addr, bus.wb_addr_a, bus.wb_addr_b}, 64'd0);
  endtask

  // Reference schedule written as the textbook loop nest
  task automatic build(input logic inv);
    iss_t e;
    int k, s;
    exp_q.delete();
    s = 0;
    if (!inv) begin
      k = 0;
      for (int len = 128; len >= 1; len = len >> 1) begin
        for (int st = 0; st < 256; st += 2 * len) begin
          k++;
          for (int j = st; j < st + len; j++) begin
            e.st = s[2:0]; e.z = k[7:0]; e.a = j[7:0]; e.b = 8'(j + len);
            exp_q.push_back(e);
          end
        end
        s++;
      end
    end else begin
      k = 256;
      for (int len = 1; len <= 128; len = len << 1) begin
        for (int st = 0; st < 256; st += 2 * len) begin
          k--;
          for (int j = st; j < st + len; j++) begin
            e.st = s[2:0]; e.z = k[7:0]; e.a = j[7:0]; e.b = 8'(j + len);
            exp_q.push_back(e);
          end
        end
        s++;
      end
    end
  endtask

  task automatic run(input logic inv, input bit rnd, input bit glitch, input bit abort);
    iss_t acc_q[$];
    int   acc_cyc[$];
    iss_t e, cur, hold_v;
    int   st0, rel, nacc, last_wb, prev_st, c;
    bit   held, fin;
    nacc = 0; last_wb = -100; prev_st = -1; held = 0; fin = 0;
    build(inv);
    @(negedge clk);
    bus.start = 1'b1; bus.inverse = inv; bus.bf_ready = 1'b1;
    st0 = cyc;
    for (int t = 0; t < 6000 && !fin; t++) begin
      @(negedge clk);
      rel = cyc - st0 + 1;
      bus.start = 1'b0;
      bus.inverse = 1'($urandom_range(0, 1));
      if (glitch && rel == 10) begin bus.start = 1'b1; bus.inverse = 1'b1; end
      if (rel == 2) chk("busy_on", bus.busy, 1);

      if (bus.wb_valid) begin
        chk("wb_spur", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          e = acc_q.pop_front(); c = acc_cyc.pop_front();
          chk("wb_lat", rel, c + L);
          chk("wb_addr", {bus.wb_addr_a, bus.wb_addr_b}, {e.a, e.b});
        end
        last_wb = rel;
      end else if (acc_cyc.size() > 0 && acc_cyc[0] + L <= rel) begin
        chk("wb_miss", bus.wb_valid, 1);
        void'(acc_q.pop_front()); void'(acc_cyc.pop_front());
      end

      cur.st = bus.stage; cur.z = bus.zeta_addr; cur.a = bus.rd_addr_a; cur.b = bus.rd_addr_b;
      if (held) chk("stall_hold", {bus.bf_valid, cur}, {1'b1, hold_v});
      held = 0;
      bus.bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.bf_valid) begin
        if (int'(bus.stage) != prev_st) begin
          if (prev_st >= 0) chk("stage_gap", rel, last_wb + 1);
          prev_st = int'(bus.stage);
        end
        chk("zeta_neg", bus.zeta_neg, inv);
        if (bus.bf_ready) begin
          chk("exp_left", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue", cur, e);
            acc_q.push_back(e); acc_cyc.push_back(rel);
          end
          nacc++;
          if (abort && nacc == 3 * 128 + 41) begin
            reset = 1'b0;
            #1;
            chk_zero("abort_outs");
            @(negedge clk);
            chk_zero("abort_hold");
            reset = 1'b1;
            for (int i = 0; i < 20; i++) begin
              @(negedge clk);
              chk("post_rst", {bus.wb_valid, bus.bf_valid, bus.busy}, 3'b000);
            end
            return;
          end
        end else begin
          held = 1; hold_v = cur;
        end
      end

      if (bus.done) begin
        fin = 1;
        chk("busy_fall", bus.busy, 0);
        if (!rnd) chk("done_cyc", rel, 8 * (128 + L) + 2);
        chk("n_issued", nacc, 1024);
        chk("wb_left", acc_q.size(), 0);
      end
    end
    chk("finished", fin, 1);
    @(negedge clk);
    chk("done_pulse", {bus.done, bus.busy, bus.bf_valid}, 3'b000);
  endtask

  initial begin
    bus.start = 1'b0; bus.inverse = 1'b0; bus.bf_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outs");
    reset = 1'b1;
    @(negedge clk);
    chk_zero("idle_outs");

    run(1'b0, 1'b0, 1'b0, 1'b0);   // forward, always ready
    run(1'b1, 1'b0, 1'b0, 1'b0);   // inverse, always ready
    run(1'b0, 1'b1, 1'b0, 1'b0);   // forward, random stalls
    run(1'b0, 1'b0, 1'b0, 1'b1);   // reset at s=3 b=40
    run(1'b0, 1'b0, 1'b0, 1'b0);   // fresh forward after reset
    run(1'b0, 1'b0, 1'b1, 1'b0);   // start+inverse pulsed while busy

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ntt_sched_ctrl.md
NTT_SCHED_CTRL -- requirements
Module: ntt_sched_ctrl

Interface
REQ-001 Parameter BF_LAT, default 4, meaning: butterfly pipeline latency in cycles from accepted issue to write-back; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a 256-point transform; sampled only in IDLE.
REQ-005 inverse  input  1  0 = forward (Cooley-Tukey), 1 = inverse (Gentleman-Sande); sampled with start.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse at transform completion.
REQ-008 bf_valid  output  1  issue slot holds a valid butterfly.
REQ-009 bf_ready  input  1  datapath/memory accepts the issue this cycle.
REQ-010 rd_addr_a, rd_addr_b  output  8 each  coefficient indices j and j+len of the current butterfly.
REQ-011 zeta_addr  output  8  twiddle ROM address for the current butterfly.
REQ-012 zeta_neg  output  1  equals latched inverse; datapath negates the twiddle when high.
REQ-013 stage  output  3  current stage index s, 0..7.
REQ-014 wb_valid  output  1  write back the butterfly result this cycle.
REQ-015 wb_addr_a, wb_addr_b  output  8 each  write-back indices matching the issue BF_LAT cycles earlier.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN, FINISH; transitions: IDLE->ISSUE on start; ISSUE->DRAIN when butterfly b=127 is accepted; DRAIN->ISSUE (s+1) when s<7 and the write-back pipe is empty; DRAIN->FINISH when s=7 and the pipe is empty; FINISH->IDLE unconditionally.
REQ-017 Internal counters: stage s (3 bits), butterfly index b (7 bits); both cleared on start and b cleared on each new stage.
REQ-018 An issue is accepted when bf_valid && bf_ready; b increments only on acceptance.
REQ-019 bf_valid shall be high only in ISSUE; while bf_ready is low, all issue outputs shall hold stable.
REQ-020 Forward: len = 128>>s; rd_addr_a = ((b>>(7-s))<<(8-s)) + (b mod len); rd_addr_b = rd_addr_a + len; zeta_addr = (1<<s) + (b>>(7-s)).
REQ-021 Inverse: len = 1<<s; rd_addr_a = ((b>>s)<<(s+1)) + (b mod len); rd_addr_b = rd_addr_a + len; zeta_addr = (256>>s) - 1 - (b>>s).
REQ-022 All address arithmetic is 8-bit unsigned; rd_addr_b never exceeds 255 by construction; zeta_addr range 1..255, never 0.
REQ-023 Each accepted issue shall enter a BF_LAT-deep shift pipe; wb_valid, wb_addr_a and wb_addr_b shall appear exactly BF_LAT cycles after acceptance, independent of bf_ready.
REQ-024 DRAIN exists to guarantee that no stage s+1 read precedes the last stage-s write; first issue of stage s+1 occurs no earlier than the cycle after the final stage-s wb_valid.
REQ-025 done shall pulse in FINISH; busy shall fall in the same cycle done is high.
REQ-026 start while busy shall be ignored; inverse changes mid-transform shall have no effect.
REQ-027 Total cycles from start to done with bf_ready held high: 8*(128+BF_LAT) + 2.

Reset
REQ-028 reset low shall immediately force IDLE and clear s, b, the write-back pipe, busy, done, bf_valid, wb_valid and all address outputs to 0.
REQ-029 Reset mid-transform shall discard all in-flight write-backs; no wb_valid shall assert after reset release until a new start.
REQ-030 zeta_neg shall reset to 0.

Verification
REQ-031 Forward, BF_LAT=4, bf_ready=1: first issue a=0,b=128,zeta=1; stage 1 first issue a=0,b=64,zeta=2; last issue (s=7,b=127) a=254,b=255,zeta=255; done at cycle 1058.
REQ-032 Inverse, bf_ready=1: first issue a=0,b=1,zeta=255; s=1,b=0: a=0,b=2,zeta=127; last issue a=127,b=255,zeta=1; zeta_neg=1 throughout.
REQ-033 Random bf_ready toggling (50%): issue sequence identical to REQ-031; each wb pair equals issue pair delayed exactly BF_LAT cycles after acceptance; total accepted issues 1024.
REQ-034 Stage boundary: bf_ready=1; check no bf_valid during the BF_LAT cycles after the last issue of each stage, and first next-stage issue follows the final wb_valid.
REQ-035 Reset asserted at s=3,b=40 with pipe full -> all outputs 0 next sample, no wb_valid after release; fresh start reproduces REQ-031.
REQ-036 start pulsed at cycle 10 of a running forward transform with inverse=1 -> ignored; schedule and done timing unchanged.
